// File: rtl/lsu_ctrl_pkg.sv
// lsu_pkg: shared width encodings, FSM state type and alignment helper
// for the load/store sequencer and its lane-alignment datapath.
package lsu_pkg;

    localparam logic [1:0] LSU_W_B = 2'b00;
    localparam logic [1:0] LSU_W_H = 2'b01;
    localparam logic [1:0] LSU_W_W = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lsu_state_t;

    // Reserved width (2'b10) is never aligned, so it takes the misalign path.
    function automatic logic is_aligned(
        input logic [1:0] w,
        input logic [1:0] off
    );
        return (w == LSU_W_B) ||
               (w == LSU_W_H && !off[0]) ||
               (w == LSU_W_W && off == 2'b00);
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: data-memory request/ack bus between the LSU and memory.
// master = LSU side (drives req/we/addr/be/wdata), slave = memory side.
interface lsu_ctrl_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/lsu_ctrl_lane_align.sv
// lsu_lane_align: combinational byte-lane logic. Store side: i_st_* ->
// o_be/o_st_data. Load side: i_ld_* + read word -> extended o_ld_data.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  i_st_width,
    input  logic [1:0]  i_st_off,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_st_data,
    input  logic [1:0]  i_ld_width,
    input  logic [1:0]  i_ld_off,
    input  logic        i_ld_sign,
    input  logic [31:0] i_ld_data,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_ld_data[8*i_ld_off +: 8];
    assign w_half = i_ld_data[16*i_ld_off[1] +: 16];

    always_comb begin
        o_be      = 4'b0000;
        o_st_data = i_st_data;
        case (i_st_width)
            LSU_W_B: begin
                o_be      = 4'b0001 << i_st_off;
                o_st_data = {4{i_st_data[7:0]}};
            end
            LSU_W_H: begin
                o_be      = i_st_off[1] ? 4'b1100 : 4'b0011;
                o_st_data = {2{i_st_data[15:0]}};
            end
            LSU_W_W: o_be = 4'b1111;
            default: o_be = 4'b0000;
        endcase
    end

    always_comb begin
        o_ld_data = i_ld_data;
        case (i_ld_width)
            LSU_W_B: o_ld_data = {{24{i_ld_sign & w_byte[7]}}, w_byte};
            LSU_W_H: o_ld_data = {{16{i_ld_sign & w_half[15]}}, w_half};
            default: o_ld_data = i_ld_data;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer (IDLE->BUSY->RESP). Core side: start,
// is_load, is_store, width, load_sign, addr, wdata -> stall, done, rd_data,
// misalign, bus_err. Memory side: lsu_ctrl_if.master. Optional macro
// LSU_TIMEOUT_EN aborts BUSY after TIMEOUT cycles without mem_ack.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              is_load,
    input  logic              is_store,
    input  logic [1:0]        width,
    input  logic              load_sign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rd_data,
    output logic              misalign,
    output logic              bus_err,
    lsu_ctrl_if.master        mem
);

    if (2**CNT_W <= TIMEOUT) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT");
    end

    lsu_state_t  r_state, w_state_nx;
    logic        r_we;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [3:0]  r_be;
    logic [1:0]  r_width, r_off;
    logic        r_sign;

    logic        w_op, w_aligned, w_launch, w_finish;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_ld;

    assign w_op      = start & (is_load | is_store);
    assign w_aligned = is_aligned(width, addr[1:0]);

    lsu_lane_align u_align (
        .i_st_width (width),
        .i_st_off   (addr[1:0]),
        .i_st_data  (wdata),
        .o_be       (w_be),
        .o_st_data  (w_wdata),
        .i_ld_width (r_width),
        .i_ld_off   (r_off),
        .i_ld_sign  (r_sign),
        .i_ld_data  (mem.mem_rdata),
        .o_ld_data  (w_ld)
    );

`ifdef LSU_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic             r_berr;
    logic             w_abort, w_cnt_hit;

    // Hit when this BUSY cycle would make the no-ack count equal TIMEOUT.
    assign w_cnt_hit = (r_cnt == CNT_W'(TIMEOUT - 1));
`endif

    always_comb begin
        w_state_nx = r_state;
        stall      = 1'b0;
        done       = 1'b0;
        misalign   = 1'b0;
        w_launch   = 1'b0;
        w_finish   = 1'b0;
`ifdef LSU_TIMEOUT_EN
        w_abort    = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (w_op && w_aligned) begin
                    stall      = 1'b1;
                    w_launch   = 1'b1;
                    w_state_nx = BUSY;
                end else if (w_op) begin
                    misalign   = 1'b1;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem.mem_ack) begin
                    w_finish   = 1'b1;
                    w_state_nx = RESP;
                end
`ifdef LSU_TIMEOUT_EN
                else if (w_cnt_hit) begin
                    w_abort    = 1'b1;
                    w_state_nx = RESP;
                end
`endif
            end
            RESP: begin
                done       = 1'b1;
                w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_width <= '0;
            r_off   <= '0;
            r_sign  <= 1'b0;
            r_rd    <= '0;
        end else begin
            r_state <= w_state_nx;
            if (w_launch) begin
                r_addr  <= {addr[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
                r_we    <= is_store;
                r_width <= width;
                r_off   <= addr[1:0];
                r_sign  <= load_sign;
            end
            if (w_finish) begin
                r_rd <= r_we ? 32'h0 : w_ld;
            end
`ifdef LSU_TIMEOUT_EN
            if (w_abort) begin
                r_rd <= 32'h0;
            end
`endif
        end
    end

`ifdef LSU_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_berr <= 1'b0;
        end else begin
            if (w_launch) begin
                r_cnt <= '0;
            end else if (r_state == BUSY && !mem.mem_ack) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_finish || w_abort) begin
                r_berr <= w_abort;
            end
        end
    end

    assign bus_err = (r_state == RESP) & r_berr;
`else
    assign bus_err = 1'b0;
`endif

    // Request is a pure state decode so an async reset drops it at once.
    assign mem.mem_req   = (r_state == BUSY);
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;
    assign rd_data       = r_rd;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl; expected completions are
// queued at launch and popped on each done pulse.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_load, is_store, load_sign;
    logic [1:0]  width;
    logic [31:0] addr, wdata;
    logic        stall, done, misalign, bus_err;
    logic [31:0] rd_data;

    int n_tot = 0;
    int n_bad = 0;
    int n_done = 0;

    typedef struct {
        logic [31:0] rd;
        logic        berr;
    } exp_t;

    exp_t sb[$];

    lsu_ctrl_if mif ();

    lsu_ctrl #(
        .TIMEOUT (4),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_load   (is_load),
        .is_store  (is_store),
        .width     (width),
        .load_sign (load_sign),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rd_data   (rd_data),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem       (mif.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] be_model(input logic [1:0] w,
                                            input logic [1:0] off);
        if (w == 2'b11) return 4'b1111;
        if (w == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        case (off)
            2'd0: return 4'b0001;
            2'd1: return 4'b0010;
            2'd2: return 4'b0100;
            default: return 4'b1000;
        endcase
    endfunction

    function automatic logic [31:0] wd_model(input logic [1:0] w,
                                             input logic [31:0] d);
        if (w == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (w == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] ld_model(input logic [1:0] w,
                                             input logic sg,
                                             input logic [1:0] off,
                                             input logic [31:0] rd);
        logic [31:0] sh;
        if (w == 2'b00) begin
            sh = rd >> (8 * off);
            return (sg && sh[7]) ? (sh | 32'hFFFF_FF00) : (sh & 32'hFF);
        end
        if (w == 2'b01) begin
            sh = rd >> (off[1] ? 16 : 0);
            return (sg && sh[15]) ? (sh | 32'hFFFF_0000) : (sh & 32'hFFFF);
        end
        return rd;
    endfunction

    always @(negedge clk) begin
        if (!rst && done) begin
            n_done++;
            if (sb.size() == 0) begin
                chk("spurious_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", rd_data, e.rd);
                chk("bus_err", bus_err, e.berr);
            end
        end
    end

    // Called just after a posedge; returns just after a posedge.
    task automatic run_op(input bit ld, input bit st, input logic [1:0] w,
                          input bit sg, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdat,
                          input int d, input bit tmo);
        bit   op, al;
        exp_t e;
        op = ld | st;
        al = (w == 2'b00) || (w == 2'b01 && !a[0]) ||
             (w == 2'b11 && a[1:0] == 2'b00);
        start = 1'b1; is_load = ld; is_store = st; width = w;
        load_sign = sg; addr = a; wdata = wd;
        mif.mem_ack = 1'b0; mif.mem_rdata = rdat;
        @(negedge clk);
        chk("stall_idle", stall, op & al);
        chk("misalign", misalign, op & !al);
        chk("req_idle", mif.mem_req, 1'b0);
        if (!(op && al)) begin
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            chk("req_none", mif.mem_req, 1'b0);
            chk("stall_none", stall, 1'b0);
            chk("misalign_gone", misalign, 1'b0);
            @(posedge clk); #1;
            return;
        end
        e.rd   = (st || tmo) ? 32'h0 : ld_model(w, sg, a[1:0], rdat);
        e.berr = tmo;
        sb.push_back(e);
        @(posedge clk); #1;
        for (int i = 0; i <= d; i++) begin
            mif.mem_ack = (i == d) && !tmo;
            @(negedge clk);
            chk("req_busy", mif.mem_req, 1'b1);
            chk("stall_busy", stall, 1'b1);
            chk("done_busy", done, 1'b0);
            chk("mem_addr", mif.mem_addr, {a[31:2], 2'b00});
            chk("mem_be", mif.mem_be, be_model(w, a[1:0]));
            chk("mem_wdata", mif.mem_wdata, wd_model(w, wd));
            chk("mem_we", mif.mem_we, st);
            @(posedge clk); #1;
        end
        mif.mem_ack = 1'b0;
        @(negedge clk);
        chk("done_resp", done, 1'b1);
        chk("stall_resp", stall, 1'b0);
        chk("req_resp", mif.mem_req, 1'b0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("done_after", done, 1'b0);
        chk("req_after", mif.mem_req, 1'b0);
        chk("stall_after", stall, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  w;
        logic [31:0] a;
        int          n_exp;
        rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0;
        width = 2'b00; load_sign = 1'b0; addr = '0; wdata = '0;
        mif.mem_ack = 1'b0; mif.mem_rdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", mif.mem_req, 1'b0);
        chk("rst_we", mif.mem_we, 1'b0);
        chk("rst_addr", mif.mem_addr, 32'h0);
        chk("rst_be", mif.mem_be, 4'h0);
        chk("rst_wdata", mif.mem_wdata, 32'h0);
        chk("rst_rd", rd_data, 32'h0);
        chk("rst_done", done, 1'b0);
        chk("rst_berr", bus_err, 1'b0);
        @(posedge clk); #1 rst = 1'b0;
        n_exp = 0;

        // SW, ack on second BUSY cycle
        run_op(0, 1, 2'b11, 0, 32'h104, 32'hDEADBEEF, 32'h0, 1, 0);
        n_exp++;
        // LB / LBU at lane 3
        run_op(1, 0, 2'b00, 1, 32'h203, 32'h0, 32'h80112233, 0, 0);
        run_op(1, 0, 2'b00, 0, 32'h203, 32'h0, 32'h80112233, 0, 0);
        n_exp += 2;
        // SH upper half, then misaligned LH and reserved width
        run_op(0, 1, 2'b01, 0, 32'h302, 32'h0000ABCD, 32'h0, 0, 0);
        n_exp++;
        run_op(1, 0, 2'b01, 1, 32'h301, 32'h0, 32'h0, 0, 0);
        run_op(1, 0, 2'b10, 0, 32'h300, 32'h0, 32'h0, 0, 0);
        run_op(1, 0, 2'b11, 0, 32'h302, 32'h0, 32'h0, 0, 0);
        // start with neither load nor store: no op
        run_op(0, 0, 2'b11, 0, 32'h500, 32'h0, 32'h0, 0, 0);
        // LW with 10 wait cycles
        run_op(1, 0, 2'b11, 0, 32'h400, 32'h0, 32'h12345678, 10, 0);
        n_exp++;
        // load+store together acts as store
        run_op(1, 1, 2'b00, 1, 32'h601, 32'h000000F0, 32'hFFFFFFFF, 0, 0);
        n_exp++;
        // LH / LHU lower and upper halves
        run_op(1, 0, 2'b01, 1, 32'h700, 32'h0, 32'h7FFF8001, 0, 0);
        run_op(1, 0, 2'b01, 0, 32'h702, 32'h0, 32'h8001CAFE, 1, 0);
        n_exp += 2;

        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 2))
                0: w = 2'b00;
                1: w = 2'b01;
                default: w = 2'b11;
            endcase
            a = $urandom;
            if (w == 2'b01) a[0] = 1'b0;
            if (w == 2'b11) a[1:0] = 2'b00;
            run_op(1, 0, w, 1'($urandom_range(0, 1)), a, 32'h0, $urandom,
                   int'($urandom_range(0, 2)), 0);
            n_exp++;
        end

        // reset during BUSY, then a stray ack
        start = 1'b1; is_load = 1'b1; is_store = 1'b0; width = 2'b11;
        addr = 32'h800; load_sign = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("req_pre_rst", mif.mem_req, 1'b1);
        #2 rst = 1'b1;
        #1 chk("req_async_rst", mif.mem_req, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0; mif.mem_ack = 1'b1;
        @(negedge clk);
        chk("done_stray", done, 1'b0);
        chk("req_stray", mif.mem_req, 1'b0);
        chk("stall_stray", stall, 1'b0);
        @(posedge clk); #1 mif.mem_ack = 1'b0;
        @(negedge clk);
        chk("done_stray2", done, 1'b0);
        @(posedge clk); #1;
        run_op(1, 0, 2'b00, 1, 32'h901, 32'h0, 32'h0000FF00, 0, 0);
        n_exp++;

`ifdef LSU_TIMEOUT_EN
        run_op(1, 0, 2'b11, 0, 32'hA00, 32'h0, 32'h55AA55AA, 3, 1);
        n_exp++;
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("sb_left", sb.size(), 0);
        chk("done_count", n_done, n_exp);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
